// File: rtl/rf_wport_arbiter_pkg.sv
// rtl/rf_wport_arbiter_pkg.sv - shared widths and arbiter FSM state encoding
package rf_wport_arbiter_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - sync FIFO of pending long-unit writebacks with per-entry rd visibility
module rf_wb_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [REG_W-1:0]        push_rd_i,
  input  logic [XLEN-1:0]         push_data_i,
  input  logic                    pop_i,
  output logic [REG_W-1:0]        head_rd_o,
  output logic [XLEN-1:0]         head_data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic [DEPTH-1:0]        ent_valid_o,
  output logic [REG_W-1:0]        ent_rd_o [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic [DEPTH-1:0] valid_q;
  logic [REG_W-1:0] rd_mem_q   [DEPTH];
  logic [XLEN-1:0]  data_mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      // Push and pop never hit the same slot: push needs !full, pop needs !empty.
      if (do_push) begin
        wr_ptr_q          <= wr_ptr_q + PW'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q          <= rd_ptr_q + PW'(1);
        valid_q[rd_ptr_q] <= 1'b0;
      end
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      rd_mem_q[wr_ptr_q]   <= push_rd_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_rd_o   = rd_mem_q[rd_ptr_q];
  assign head_data_o = data_mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign ent_valid_o = valid_q;
  assign ent_rd_o    = rd_mem_q;

endmodule

// File: rtl/rf_wport_arbiter.sv
// rtl/rf_wport_arbiter.sv - shares the regfile write port between writeback and a queued long unit
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_en_i,
  input  logic [REG_W-1:0] wb_rd_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic             wb_stall_o,
  input  logic             lu_valid_i,
  input  logic [REG_W-1:0] lu_rd_i,
  input  logic [XLEN-1:0]  lu_data_i,
  output logic             lu_ready_o,
  output logic             rf_w_en_o,
  output logic [REG_W-1:0] rf_rd_o,
  output logic [XLEN-1:0]  rf_data_o,
  input  logic [REG_W-1:0] rs1_id_i,
  input  logic [REG_W-1:0] rs2_id_i,
  input  logic [REG_W-1:0] rd_chk_id_i,
  output logic             hazard_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  arb_state_e       state_q;
  logic [CW-1:0]    wait_cnt_q, wait_cnt_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REG_W-1:0] head_rd;
  logic [XLEN-1:0]  head_data;
  logic [PW:0]      fifo_count, count_next;
  logic [DEPTH-1:0] ent_valid;
  logic [REG_W-1:0] ent_rd [DEPTH];

  logic             wb_live, force_drain, hazard;

  // x0 results are acknowledged but never stored.
  assign lu_ready_o  = !fifo_full;
  assign fifo_push   = lu_valid_i && !fifo_full && (lu_rd_i != '0);
  assign wb_live     = wb_en_i && (wb_rd_i != '0);
  assign force_drain = (state_q == ARB_FORCE) && !fifo_empty;
  assign fifo_pop    = !fifo_empty && (force_drain || !wb_live);
  assign wb_stall_o  = force_drain;
  assign count_next  = fifo_count + (PW+1)'(fifo_push) - (PW+1)'(fifo_pop);
  assign wait_cnt_d  = wait_cnt_q + CW'(1);

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_rd_i   (lu_rd_i),
    .push_data_i (lu_data_i),
    .pop_i       (fifo_pop),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .ent_valid_o (ent_valid),
    .ent_rd_o    (ent_rd)
  );

  always_comb begin
    rf_w_en_o = 1'b0;
    rf_rd_o   = '0;
    rf_data_o = '0;
    if (force_drain || (!wb_live && !fifo_empty)) begin
      rf_w_en_o = 1'b1;
      rf_rd_o   = head_rd;
      rf_data_o = head_data;
    end else if (wb_live) begin
      rf_w_en_o = 1'b1;
      rf_rd_o   = wb_rd_i;
      rf_data_o = wb_data_i;
    end
  end

  // The FORCE decision uses the incremented count so the forced drain lands
  // MAX_WAIT cycles after the head started waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      wait_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          wait_cnt_q <= '0;
          if (fifo_push) state_q <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (fifo_pop) begin
            wait_cnt_q <= '0;
            if (count_next == '0) state_q <= ARB_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d >= WAIT_LAST) state_q <= ARB_FORCE;
          end
        end
        ARB_FORCE: begin
          wait_cnt_q <= '0;
          state_q    <= (count_next == '0) ? ARB_IDLE : ARB_WAIT;
        end
        default: begin
          wait_cnt_q <= '0;
          state_q    <= ARB_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] != '0) &&
          ((ent_rd[i] == rs1_id_i) || (ent_rd[i] == rs2_id_i) || (ent_rd[i] == rd_chk_id_i)))
        hazard = 1'b1;
    end
  end

  assign hazard_o = hazard;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb/tb_rf_wport_arbiter.sv - directed stimulus with a queue-based reference model
module tb_rf_wport_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_en_i = 1'b0, lu_valid_i = 1'b0;
  logic [4:0]  wb_rd_i = '0, lu_rd_i = '0, rs1_id_i = '0, rs2_id_i = '0, rd_chk_id_i = '0;
  logic [31:0] wb_data_i = '0, lu_data_i = '0;
  logic        wb_stall_o, lu_ready_o, rf_w_en_o, hazard_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;

  int checks = 0;
  int errors = 0;

  rf_wport_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_en_i     (wb_en_i),
    .wb_rd_i     (wb_rd_i),
    .wb_data_i   (wb_data_i),
    .wb_stall_o  (wb_stall_o),
    .lu_valid_i  (lu_valid_i),
    .lu_rd_i     (lu_rd_i),
    .lu_data_i   (lu_data_i),
    .lu_ready_o  (lu_ready_o),
    .rf_w_en_o   (rf_w_en_o),
    .rf_rd_o     (rf_rd_o),
    .rf_data_o   (rf_data_o),
    .rs1_id_i    (rs1_id_i),
    .rs2_id_i    (rs2_id_i),
    .rd_chk_id_i (rd_chk_id_i),
    .hazard_o    (hazard_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending results plus count of starved cycles.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_starve = 0;
  bit          m_force, m_live, m_pop, m_nonempty, m_rdy, m_hz, m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_rst_wen", rf_w_en_o, 0);
      chk("m_rst_rd", rf_rd_o, 0);
      chk("m_rst_data", rf_data_o, 0);
      chk("m_rst_stall", wb_stall_o, 0);
      chk("m_rst_ready", lu_ready_o, 1);
      chk("m_rst_hazard", hazard_o, 0);
      mq.delete();
      m_starve = 0;
    end else begin
      m_nonempty = (mq.size() > 0);
      m_live     = wb_en_i && (wb_rd_i != 0);
      m_force    = m_nonempty && (m_starve >= MAX_WAIT - 1);
      m_pop      = m_nonempty && (m_force || !m_live);
      m_wen = 0; m_rd = 0; m_data = 0;
      if (m_pop) begin
        m_wen = 1; m_rd = mq[0].rd; m_data = mq[0].data;
      end else if (m_live) begin
        m_wen = 1; m_rd = wb_rd_i; m_data = wb_data_i;
      end
      m_rdy = (mq.size() < DEPTH);
      m_hz  = 0;
      foreach (mq[i])
        if (mq[i].rd != 0 && (mq[i].rd == rs1_id_i || mq[i].rd == rs2_id_i || mq[i].rd == rd_chk_id_i))
          m_hz = 1;
      chk("m_wen", rf_w_en_o, m_wen);
      chk("m_rd", rf_rd_o, m_rd);
      chk("m_data", rf_data_o, m_data);
      chk("m_stall", wb_stall_o, m_force);
      chk("m_ready", lu_ready_o, m_rdy);
      chk("m_hazard", hazard_o, m_hz);
      if (m_pop) void'(mq.pop_front());
      if (lu_valid_i && m_rdy && lu_rd_i != 0) mq.push_back('{rd: lu_rd_i, data: lu_data_i});
      m_starve = (m_nonempty && !m_pop) ? m_starve + 1 : 0;
    end
  end

  task automatic set_in(input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    wb_en_i = we; wb_rd_i = wrd; wb_data_i = wd;
    lu_valid_i = lv; lu_rd_i = lrd; lu_data_i = ld;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset_wen", rf_w_en_o, 0);
    chk("reset_ready", lu_ready_o, 1);
    chk("reset_stall", wb_stall_o, 0);
    adv(); adv();
    rst = 1'b1;

    // idle drain
    set_in(0, 0, 0, 1, 5, 32'hDEADBEEF);
    @(negedge clk); chk("drain_no_bypass", rf_w_en_o, 0); adv();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drain_wen", rf_w_en_o, 1);
    chk("drain_rd", rf_rd_o, 5);
    chk("drain_data", rf_data_o, 32'hDEADBEEF);
    adv();
    @(negedge clk); chk("drain_after_wen", rf_w_en_o, 0); adv();

    // priority and forced drain
    for (int k = 0; k < 10; k++) begin
      set_in(1, 7, 32'h7777_0007, k == 0, 3, 32'h3333_3333);
      @(negedge clk);
      chk("prio_stall", wb_stall_o, (k == 8) ? 1 : 0);
      chk("prio_rd", rf_rd_o, (k == 8) ? 3 : 7);
      chk("prio_data", rf_data_o, (k == 8) ? 32'h3333_3333 : 32'h7777_0007);
      adv();
    end
    set_in(0, 0, 0, 0, 0, 0);
    adv();

    // full FIFO
    for (int k = 0; k < 10; k++) begin
      set_in(1, 7, 32'h7777_0007, 1, (k < 4) ? 5'(10 + k) : 5'd14, (k < 4) ? 32'hA0 + k : 32'hA4);
      @(negedge clk);
      chk("full_ready", lu_ready_o, (k >= 4 && k <= 8) ? 0 : 1);
      if (k == 8) begin
        chk("full_force_stall", wb_stall_o, 1);
        chk("full_force_rd", rf_rd_o, 10);
      end
      adv();
    end
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) chk("full_drain_rd", rf_rd_o, 11 + i);
      else chk("full_drain_done", rf_w_en_o, 0);
      adv();
    end

    // x0 handling
    set_in(1, 0, 32'h55, 1, 20, 32'h2020);
    @(negedge clk); chk("x0_wb_nowrite", rf_w_en_o, 0); adv();
    set_in(1, 0, 32'h55, 0, 0, 0);
    @(negedge clk); chk("x0_head_wen", rf_w_en_o, 1); chk("x0_head_rd", rf_rd_o, 20); adv();
    set_in(0, 0, 0, 1, 0, 32'hBAD);
    @(negedge clk); chk("x0_lu_ready", lu_ready_o, 1); adv();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("x0_lu_nowrite", rf_w_en_o, 0); adv();

    // hazard
    set_in(1, 7, 32'h7777_0007, 1, 9, 32'h99);
    @(negedge clk); chk("hz_before", hazard_o, 0); adv();
    set_in(1, 7, 32'h7777_0007, 0, 0, 0);
    rs1_id_i = 0; rs2_id_i = 9; rd_chk_id_i = 1;
    @(negedge clk); chk("hz_rs2", hazard_o, 1); adv();
    rs2_id_i = 4; rd_chk_id_i = 6;
    @(negedge clk); chk("hz_nomatch", hazard_o, 0); adv();
    rd_chk_id_i = 9;
    @(negedge clk); chk("hz_waw", hazard_o, 1); adv();
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("hz_drain_still", hazard_o, 1); chk("hz_drain_rd", rf_rd_o, 9); adv();
    @(negedge clk); chk("hz_after", hazard_o, 0); adv();
    rs2_id_i = 0; rd_chk_id_i = 0;

    // reset mid-operation during a forced stall
    for (int k = 0; k < 8; k++) begin
      set_in(1, 7, 32'h7777_0007, k < 3, 5'(21 + k), 32'hC0 + k);
      adv();
    end
    set_in(1, 7, 32'h7777_0007, 0, 0, 0);
    rs2_id_i = 22;
    #1;
    chk("rstmid_stall_pre", wb_stall_o, 1);
    chk("rstmid_hz_pre", hazard_o, 1);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    #1;
    chk("rstmid_stall", wb_stall_o, 0);
    chk("rstmid_wen", rf_w_en_o, 0);
    chk("rstmid_ready", lu_ready_o, 1);
    chk("rstmid_hz", hazard_o, 0);
    adv();
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); chk("post_rst_nowrite", rf_w_en_o, 0);
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
